// File: rtl/set_assoc_cache_ctrl.sv
// 4-way set-associative cache controller: 256 sets of one-word blocks, write-through,
// no write-allocate, invalid-first then tree pseudo-LRU replacement on read-miss fills.
module set_assoc_cache_ctrl (
    input  logic        clk,
    input  logic        reset,
    input  logic        cpu_req,
    input  logic        cpu_we,
    input  logic [31:0] cpu_addr,
    input  logic [31:0] cpu_wdata,
    output logic        cpu_ready,
    output logic        cpu_done,
    output logic        cpu_hit,
    output logic [31:0] cpu_rdata,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic        mem_ack,
    input  logic [31:0] mem_rdata
);
    localparam int unsigned SETS   = 256;
    localparam int unsigned WAYS   = 4;
    localparam int unsigned TAG_W  = 22;
    localparam int unsigned DATA_W = 32;
    localparam int unsigned IDX_W  = 8;
    localparam int unsigned WAY_W  = 2;
    localparam logic [31:0] ADDR_MASK = 32'hFFFF_FFFC;

    typedef enum logic [2:0] {IDLE, LOOKUP, MEM_RD, MEM_WR, RESP} state_e;

    logic [WAYS-1:0][TAG_W-1:0]  tag_mem   [SETS];
    logic [WAYS-1:0][DATA_W-1:0] data_mem  [SETS];
    logic [WAYS-1:0]             valid_mem [SETS];
    logic [2:0]                  plru_mem  [SETS];

    state_e state_q, state_d;
    logic   lkp_phase_q, lkp_phase_d;
    logic   we_q, we_d;
    logic   hit_flag_q, hit_flag_d;
    logic [31:0] addr_q, addr_d, wdata_q, wdata_d;
    logic   cpu_ready_q, cpu_ready_d, cpu_done_q, cpu_done_d, cpu_hit_q, cpu_hit_d;
    logic   mem_req_q, mem_req_d, mem_we_q, mem_we_d;
    logic [31:0] cpu_rdata_q, cpu_rdata_d, mem_addr_q, mem_addr_d, mem_wdata_q, mem_wdata_d;

    logic [WAYS-1:0][TAG_W-1:0]  row_tag_q, row_tag_d;
    logic [WAYS-1:0][DATA_W-1:0] row_data_q, row_data_d;
    logic [WAYS-1:0]             row_valid_q, row_valid_d;

    logic [IDX_W-1:0]  idx;
    logic [TAG_W-1:0]  addr_tag;
    logic              hit_any;
    logic [WAY_W-1:0]  hit_way, victim, wr_way, plru_way;
    logic              wr_en, wr_fill, plru_we;
    logic [DATA_W-1:0] wr_data;
    logic [WAYS-1:0]   cur_valid;
    logic [2:0]        cur_plru;

    assign idx      = addr_q[9:2];
    assign addr_tag = addr_q[31:10];

    function automatic logic [2:0] plru_touch(input logic [2:0] p, input logic [WAY_W-1:0] way);
        logic [2:0] n;
        n = p;
        case (way)
            2'd0:    begin n[0] = 1'b1; n[1] = 1'b1; end
            2'd1:    begin n[0] = 1'b1; n[1] = 1'b0; end
            2'd2:    begin n[0] = 1'b0; n[2] = 1'b1; end
            default: begin n[0] = 1'b0; n[2] = 1'b0; end
        endcase
        return n;
    endfunction

    // Set row is registered in the first LOOKUP cycle, as from a synchronous SRAM read.
    always_comb begin
        row_tag_d   = row_tag_q;
        row_data_d  = row_data_q;
        row_valid_d = row_valid_q;
        if (state_q == LOOKUP && !lkp_phase_q) begin
            row_tag_d   = tag_mem[idx];
            row_data_d  = data_mem[idx];
            row_valid_d = valid_mem[idx];
        end
    end

    always_comb begin
        hit_any = 1'b0;
        hit_way = '0;
        for (int w = 0; w < int'(WAYS); w++) begin
            if (row_valid_q[w] && row_tag_q[w] == addr_tag) begin
                hit_any = 1'b1;
                hit_way = WAY_W'(w);
            end
        end
    end

    always_comb begin
        cur_valid = valid_mem[idx];
        cur_plru  = plru_mem[idx];
        if      (!cur_valid[0]) victim = 2'd0;
        else if (!cur_valid[1]) victim = 2'd1;
        else if (!cur_valid[2]) victim = 2'd2;
        else if (!cur_valid[3]) victim = 2'd3;
        else                    victim = cur_plru[0] ? (cur_plru[2] ? 2'd3 : 2'd2)
                                                     : (cur_plru[1] ? 2'd1 : 2'd0);
    end

    always_comb begin
        state_d     = state_q;
        lkp_phase_d = 1'b0;
        we_d        = we_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        hit_flag_d  = hit_flag_q;
        cpu_rdata_d = cpu_rdata_q;
        mem_we_d    = mem_we_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        wr_en       = 1'b0;
        wr_fill     = 1'b0;
        wr_way      = '0;
        wr_data     = wdata_q;
        plru_we     = 1'b0;
        plru_way    = '0;
        case (state_q)
            IDLE: if (cpu_req) begin
                we_d    = cpu_we;
                addr_d  = cpu_addr;
                wdata_d = cpu_wdata;
                state_d = LOOKUP;
            end
            LOOKUP: if (!lkp_phase_q) begin
                lkp_phase_d = 1'b1;
            end else begin
                hit_flag_d = hit_any;
                plru_we    = hit_any;
                plru_way   = hit_way;
                if (we_q || !hit_any) begin
                    mem_addr_d  = addr_q & ADDR_MASK;
                    mem_wdata_d = wdata_q;
                    mem_we_d    = we_q;
                end
                if (we_q) begin
                    wr_en   = hit_any;
                    wr_way  = hit_way;
                    state_d = MEM_WR;
                end else if (hit_any) begin
                    cpu_rdata_d = row_data_q[hit_way];
                    state_d     = RESP;
                end else begin
                    state_d = MEM_RD;
                end
            end
            MEM_RD: if (mem_req_q && mem_ack) begin
                wr_en       = 1'b1;
                wr_fill     = 1'b1;
                wr_way      = victim;
                wr_data     = mem_rdata;
                plru_we     = 1'b1;
                plru_way    = victim;
                cpu_rdata_d = mem_rdata;
                hit_flag_d  = 1'b0;
                state_d     = RESP;
            end
            MEM_WR: if (mem_req_q && mem_ack) state_d = RESP;
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
        cpu_ready_d = (state_d == IDLE);
        cpu_done_d  = (state_d == RESP);
        cpu_hit_d   = (state_d == RESP) && hit_flag_d;
        mem_req_d   = (state_d == MEM_RD) || (state_d == MEM_WR);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            lkp_phase_q <= 1'b0;
            we_q        <= 1'b0;
            addr_q      <= '0;
            wdata_q     <= '0;
            hit_flag_q  <= 1'b0;
            cpu_ready_q <= 1'b1;
            cpu_done_q  <= 1'b0;
            cpu_hit_q   <= 1'b0;
            cpu_rdata_q <= '0;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            for (int unsigned s = 0; s < SETS; s++) begin
                valid_mem[s] <= '0;
                plru_mem[s]  <= '0;
            end
        end else begin
            state_q     <= state_d;
            lkp_phase_q <= lkp_phase_d;
            we_q        <= we_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            hit_flag_q  <= hit_flag_d;
            cpu_ready_q <= cpu_ready_d;
            cpu_done_q  <= cpu_done_d;
            cpu_hit_q   <= cpu_hit_d;
            cpu_rdata_q <= cpu_rdata_d;
            mem_req_q   <= mem_req_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            if (wr_en && wr_fill) valid_mem[idx][wr_way] <= 1'b1;
            if (plru_we)          plru_mem[idx] <= plru_touch(plru_mem[idx], plru_way);
        end
    end

    // Tag/data storage carries no reset; entries are qualified by valid_mem.
    always_ff @(posedge clk) begin
        row_tag_q   <= row_tag_d;
        row_data_q  <= row_data_d;
        row_valid_q <= row_valid_d;
        if (wr_en && !reset) begin
            tag_mem[idx][wr_way]  <= addr_tag;
            data_mem[idx][wr_way] <= wr_data;
        end
    end

    assign cpu_ready = cpu_ready_q;
    assign cpu_done  = cpu_done_q;
    assign cpu_hit   = cpu_hit_q;
    assign cpu_rdata = cpu_rdata_q;
    assign mem_req   = mem_req_q;
    assign mem_we    = mem_we_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
endmodule

// File: tb/tb_set_assoc_cache_ctrl.sv
// Directed bench for set_assoc_cache_ctrl: hit/miss timing, PLRU replacement,
// write-through paths, ignored inputs, reset abort and zero-wait memory.
module tb_set_assoc_cache_ctrl;
    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        cpu_req = 1'b0, cpu_we = 1'b0;
    logic [31:0] cpu_addr = '0, cpu_wdata = '0;
    logic        cpu_ready, cpu_done, cpu_hit;
    logic [31:0] cpu_rdata;
    logic        mem_req, mem_we;
    logic [31:0] mem_addr, mem_wdata;
    logic        mem_ack = 1'b0;
    logic [31:0] mem_rdata, mem_rdata_drv = '0;
    logic        zw_mode = 1'b0;

    int checks = 0;
    int failures = 0;

    localparam logic [31:0] ZW_KEY = 32'hA5A5_0000;

    assign mem_rdata = zw_mode ? (mem_addr ^ ZW_KEY) : mem_rdata_drv;

    set_assoc_cache_ctrl dut (
        .clk(clk), .reset(reset),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_ready(cpu_ready), .cpu_done(cpu_done), .cpu_hit(cpu_hit), .cpu_rdata(cpu_rdata),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_ack(mem_ack), .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1; cpu_req = 1'b0; mem_ack = 1'b0;
        tick(); tick();
        reset = 1'b0;
    endtask

    // Present a request at an IDLE edge and return just after edge k+2.
    task automatic start_req(input logic we, input logic [31:0] addr, input logic [31:0] wdata);
        check("ready_before_req", 32'(cpu_ready), 32'd1);
        cpu_req = 1'b1; cpu_we = we; cpu_addr = addr; cpu_wdata = wdata;
        tick();
        cpu_req = 1'b0;
        tick();
        check("no_early_done", 32'(cpu_done), 32'd0);
        tick();
    endtask

    task automatic do_op(input string tag, input logic we, input logic [31:0] addr,
                         input logic [31:0] wdata, input int ack_dly, input logic [31:0] mdata,
                         input logic exp_mem, input logic exp_hit, input logic [31:0] exp_rdata);
        start_req(we, addr, wdata);
        if (!exp_mem) begin
            check({tag, "_done"}, 32'(cpu_done), 32'd1);
            check({tag, "_nomem"}, 32'(mem_req), 32'd0);
        end else begin
            check({tag, "_memreq"}, 32'(mem_req), 32'd1);
            check({tag, "_memwe"}, 32'(mem_we), 32'(we));
            check({tag, "_memaddr"}, mem_addr, addr & 32'hFFFF_FFFC);
            if (we) check({tag, "_memwdata"}, mem_wdata, wdata);
            for (int i = 0; i < ack_dly; i++) begin
                tick();
                check({tag, "_hold"}, {31'd0, mem_req} ^ mem_addr, 32'd1 ^ (addr & 32'hFFFF_FFFC));
            end
            mem_ack = 1'b1; mem_rdata_drv = mdata;
            tick();
            mem_ack = 1'b0;
            check({tag, "_done"}, 32'(cpu_done), 32'd1);
            check({tag, "_reqdrop"}, 32'(mem_req), 32'd0);
        end
        check({tag, "_hit"}, 32'(cpu_hit), 32'(exp_hit));
        if (!we) check({tag, "_rdata"}, cpu_rdata, exp_rdata);
        tick();
        check({tag, "_done_pulse"}, 32'(cpu_done), 32'd0);
        check({tag, "_ready"}, 32'(cpu_ready), 32'd1);
    endtask

    initial begin
        int done_cnt;
        logic seen_req;
        logic [31:0] a;

        do_reset();
        check("rst_ready", 32'(cpu_ready), 32'd1);
        check("rst_done", 32'(cpu_done), 32'd0);
        check("rst_hit", 32'(cpu_hit), 32'd0);
        check("rst_rdata", cpu_rdata, 32'd0);
        check("rst_memreq", 32'(mem_req), 32'd0);
        check("rst_memwe", 32'(mem_we), 32'd0);
        check("rst_memaddr", mem_addr, 32'd0);
        check("rst_memwdata", mem_wdata, 32'd0);

        // cold miss then rehit
        do_op("cold", 1'b0, 32'h2828, 0, 3, 32'd15000, 1'b1, 1'b0, 32'd15000);
        do_op("rehit", 1'b0, 32'h2828, 0, 0, 0, 1'b0, 1'b1, 32'd15000);

        // stray mem_ack in IDLE
        mem_ack = 1'b1; mem_rdata_drv = 32'hDEAD;
        tick();
        mem_ack = 1'b0;
        check("stray_ready", 32'(cpu_ready), 32'd1);
        check("stray_done", 32'(cpu_done), 32'd0);
        check("stray_memreq", 32'(mem_req), 32'd0);
        check("stray_rdata", cpu_rdata, 32'd15000);
        do_op("stray_rehit", 1'b0, 32'h2828, 0, 0, 0, 1'b0, 1'b1, 32'd15000);

        // replacement in set 10
        do_reset();
        do_op("fill0", 1'b0, 32'h2828, 0, 1, 32'd1, 1'b1, 1'b0, 32'd1);
        do_op("fill1", 1'b0, 32'h2C28, 0, 0, 32'd2, 1'b1, 1'b0, 32'd2);
        do_op("fill2", 1'b0, 32'h3028, 0, 2, 32'd3, 1'b1, 1'b0, 32'd3);
        do_op("fill3", 1'b0, 32'h3428, 0, 0, 32'd4, 1'b1, 1'b0, 32'd4);
        do_op("evict_w0", 1'b0, 32'h3828, 0, 0, 32'd5, 1'b1, 1'b0, 32'd5);
        do_op("old_w0_miss", 1'b0, 32'h2828, 0, 0, 32'd6, 1'b1, 1'b0, 32'd6);
        do_op("w1_hit", 1'b0, 32'h2C28, 0, 0, 0, 1'b0, 1'b1, 32'd2);
        do_op("w3_hit", 1'b0, 32'h3428, 0, 0, 0, 1'b0, 1'b1, 32'd4);
        do_op("w2_evicted", 1'b0, 32'h3028, 0, 0, 32'd7, 1'b1, 1'b0, 32'd7);
        do_op("w2_now_2828", 1'b0, 32'h2828, 0, 0, 0, 1'b0, 1'b1, 32'd6);

        // write-through paths
        do_op("wr_hit", 1'b1, 32'h2C28, 32'd777, 1, 0, 1'b1, 1'b1, 0);
        do_op("rd_after_wr", 1'b0, 32'h2C28, 0, 0, 0, 1'b0, 1'b1, 32'd777);
        do_op("wr_miss", 1'b1, 32'h4028, 32'd5, 0, 0, 1'b1, 1'b0, 0);
        do_op("no_alloc", 1'b0, 32'h4028, 0, 0, 32'd55, 1'b1, 1'b0, 32'd55);

        // cpu_req during MEM_RD is ignored
        start_req(1'b0, 32'h0100, 0);
        check("ign_memreq", 32'(mem_req), 32'd1);
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 32'h0004;
        tick(); tick();
        check("ign_ready_low", 32'(cpu_ready), 32'd0);
        check("ign_addr_stable", mem_addr, 32'h0100);
        cpu_req = 1'b0; mem_ack = 1'b1; mem_rdata_drv = 32'h1111;
        tick();
        mem_ack = 1'b0;
        check("ign_rdata", cpu_rdata, 32'h1111);
        done_cnt = int'(cpu_done);
        seen_req = 1'b0;
        for (int i = 0; i < 6; i++) begin
            tick();
            done_cnt += int'(cpu_done);
            seen_req |= mem_req;
        end
        check("ign_one_done", 32'(done_cnt), 32'd1);
        check("ign_no_service", 32'(seen_req), 32'd0);

        // reset during MEM_RD abandons the fill
        start_req(1'b0, 32'h0200, 0);
        check("rmid_memreq", 32'(mem_req), 32'd1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("rmid_reqlow", 32'(mem_req), 32'd0);
        check("rmid_ready", 32'(cpu_ready), 32'd1);
        done_cnt = int'(cpu_done);
        for (int i = 0; i < 3; i++) begin
            tick();
            done_cnt += int'(cpu_done);
        end
        check("rmid_no_done", 32'(done_cnt), 32'd0);
        do_op("rmid_reread", 1'b0, 32'h0200, 0, 0, 32'h222, 1'b1, 1'b0, 32'h222);
        do_op("rmid_cleared", 1'b0, 32'h2828, 0, 0, 32'h333, 1'b1, 1'b0, 32'h333);

        // zero-wait memory: 256 sequential cold misses
        do_reset();
        zw_mode = 1'b1; mem_ack = 1'b1;
        for (int i = 0; i < 256; i++) begin
            a = 32'(i) << 2;
            start_req(1'b0, a, 0);
            check("zw_not_done_k2", 32'(cpu_done), 32'd0);
            tick();
            check("zw_done_k3", 32'(cpu_done), 32'd1);
            check("zw_hit", 32'(cpu_hit), 32'd0);
            check("zw_rdata", cpu_rdata, a ^ ZW_KEY);
            tick();
        end
        start_req(1'b0, 32'h0000, 0);
        check("zw_rehit_first", {cpu_done, cpu_hit, 30'd0}, {1'b1, 1'b1, 30'd0});
        check("zw_rehit_first_d", cpu_rdata, ZW_KEY);
        tick();
        start_req(1'b0, 32'h03FC, 0);
        check("zw_rehit_last", {cpu_done, cpu_hit, 30'd0}, {1'b1, 1'b1, 30'd0});
        check("zw_rehit_last_d", cpu_rdata, 32'h03FC ^ ZW_KEY);
        tick();
        mem_ack = 1'b0; zw_mode = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/set_assoc_cache_ctrl.md
# set_assoc_cache_ctrl

Controller side of the 4-way set-associative cache: owns tag/valid/data storage for 256 sets × 4 ways of one-word blocks and handles CPU read/write requests. On a read miss it initiates a memory read and fills a way chosen by invalid-first then tree pseudo-LRU replacement. Writes go through to memory. It sits between the processor-side request port and the word-addressed RAM model.

## Interface
Parameters:
- none (geometry fixed: 256 sets, 4 ways, 32-bit words, 22-bit tag = addr[31:10], index = addr[9:2], addr[1:0] ignored)

Ports:
- clk  in  1  single clock; all state changes on posedge
- reset  in  1  synchronous, active-high
- cpu_req  in  1  request strobe; sampled only while cpu_ready=1
- cpu_we  in  1  0 = read, 1 = write
- cpu_addr  in  32  byte address
- cpu_wdata  in  32  write data
- cpu_ready  out  1  high only in IDLE
- cpu_done  out  1  one-cycle completion pulse
- cpu_hit  out  1  valid with cpu_done: 1 = hit
- cpu_rdata  out  32  read data, valid with cpu_done on reads
- mem_req  out  1  memory request, held until acked
- mem_we  out  1  0 = read, 1 = write; stable while mem_req=1
- mem_addr  out  32  {cpu_addr[31:2], 2'b00}; stable while mem_req=1
- mem_wdata  out  32  write data; stable while mem_req=1
- mem_ack  in  1  completion; mem_rdata valid same cycle on reads
- mem_rdata  in  32  memory read data

## Operation
- States: IDLE, LOOKUP, MEM_RD, MEM_WR, RESP.
- IDLE: cpu_ready=1. Posedge with cpu_req=1 latches we/addr/wdata -> LOOKUP.
- LOOKUP: compare latched tag with all 4 ways of the set; hit = valid & tag match (at most one way matches by construction).
  - read hit: latch way data into cpu_rdata, hit flag=1, update PLRU -> RESP.
  - read miss -> MEM_RD.
  - write hit: write wdata into hit way, update PLRU, hit flag=1 -> MEM_WR.
  - write miss: no allocation, hit flag=0 -> MEM_WR.
- MEM_RD: mem_req=1, mem_we=0. On edge with mem_ack=1:
  - choose victim: lowest-index invalid way, else PLRU victim;
  - write tag/data/valid=1; update PLRU; cpu_rdata=mem_rdata; hit flag=0 -> RESP.
- MEM_WR: mem_req=1, mem_we=1, mem_wdata=latched wdata. On mem_ack -> RESP.
- RESP: cpu_done=1, cpu_hit=hit flag for exactly one cycle -> IDLE.
- PLRU, 3 bits per set {b0,b1,b2}:
  - victim: b0=0 -> (b1=0 ? way0 : way1); b0=1 -> (b2=0 ? way2 : way3).
  - on access: way0 -> b0=1, b1=1; way1 -> b0=1, b1=0; way2 -> b0=0, b2=1; way3 -> b0=0, b2=0. Other bits are unchanged.
  - accesses that update PLRU: read hit, fill, write hit.
- cpu_req while not IDLE: ignored, not queued. mem_ack while mem_req=0: ignored.

## Timing
- Reset (any state): state=IDLE; all valid and PLRU bits cleared; cpu_done=0, cpu_hit=0, cpu_rdata=0, mem_req=0, mem_we=0, mem_addr=0, mem_wdata=0. cpu_ready=1 in the first cycle after reset deasserts.
- Reset mid-transaction: transaction is abandoned; mem_req is low in the cycle after the reset edge; no fill and no cpu_done.
- Request accepted at edge k:
  - read hit: cpu_done high in the cycle after edge k+2.
  - miss/write: mem_req high from edge k+2; mem_ack seen at edge m -> mem_req low and cpu_done high after edge m; cpu_ready high after edge m+1.
- Minimum mem_ack latency: same cycle mem_req is first seen high (1-cycle memory).
- Back-to-back requests: the next accept is possible at the edge where cpu_ready=1, i.e. with no gap after RESP.
- mem_req/mem_we/mem_addr/mem_wdata are registered and glitch-free.

## Test plan
- Cold read then rehit: after reset, read 0x2828 (set 10, tag 10) -> mem_req, mem_addr=0x2828, mem_we=0; ack 3 cycles later with 15000 -> cpu_done, cpu_hit=0, cpu_rdata=15000. Read 0x2828 again -> no mem_req, cpu_done 2 cycles after accept, cpu_hit=1, rdata=15000.
- Replacement: fill set 10 by reading 0x2828, 0x2C28, 0x3028, 0x3428 (data 1, 2, 3, 4) -> ways 0..3. Read 0x3828 -> miss, fills way0. Then read 0x2828 -> miss; read 0x2C28 -> hit, rdata=2.
- Write paths: write 777 to 0x2C28 (hit) -> mem_we=1, mem_addr=0x2C28, mem_wdata=777, cpu_hit=1; later read 0x2C28 -> hit, 777. Write 5 to 0x4028 (miss) -> memory write, cpu_hit=0; next read 0x4028 -> miss.
- Ignored inputs: assert cpu_req with addr 0x0004 during MEM_RD -> not serviced; only one cpu_done. Pulse mem_ack in IDLE -> no state or output change.
- Reset mid-miss: reset asserted during MEM_RD -> mem_req=0 and cpu_ready=1 next cycles; reread of the same address misses (valid cleared).
- Zero-wait memory: mem_ack tied high -> read miss completes with cpu_done 3 cycles after accept; 256 sequential misses to distinct sets all fill way0.
